// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared constants and helpers for updown_counter
// Purpose: direction/mode encodings and the load clamp used by updown_counter.
// Ports: none (package).
// Config macro: UPDOWN_COUNTER_PRESCALE_EN (consumed by updown_counter and prescale_tick).
package updown_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Loaded values above the terminal value are pinned to it so count never
  // leaves the legal range 0..max_count.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] val,
                                               input logic [31:0] max_count);
    return (val > max_count) ? max_count : val;
  endfunction

endpackage

// File: rtl/prescale_tick.sv
// rtl/prescale_tick.sv - divide-by-PRESCALE step qualifier for updown_counter
// Purpose: asserts tick when the internal divider sits at PRESCALE-1; the
//   divider advances only while enable=1 and restarts from 0 on clear.
// Ports: clk (rising edge), reset (async, active low), enable (advance),
//   clear (sync restart), tick (divider at terminal phase).
// Config macro: UPDOWN_COUNTER_PRESCALE_EN; the module exists only when defined.
`ifdef UPDOWN_COUNTER_PRESCALE_EN
module prescale_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] phase;

  assign tick = (phase == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= (phase == LAST) ? '0 : phase + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - parametrised up/down counter with load, wrap/saturate, tc and sticky ovf
// Purpose: general-purpose event/timer counter, range 0..MAX_COUNT.
// Ports: clk, reset (async, active low), enable, up_dn (1=up), load,
//   load_val[WIDTH], sat_mode (1=saturate), clr_ovf, count[WIDTH], tc, ovf.
// Config macro: UPDOWN_COUNTER_PRESCALE_EN adds parameter PRESCALE and gates
//   steps through prescale_tick.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  ,
  parameter int unsigned      PRESCALE  = 1
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic             step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             hit_max;
  logic             hit_zero;
  logic             boundary;
  logic [WIDTH-1:0] next_count;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  logic tick;

  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .tick   (tick)
  );

  assign step = enable & tick & ~load;
`else
  assign step = enable & ~load;
`endif

  // One extra bit keeps the increment from carrying out silently when
  // MAX_COUNT is all ones, and turns the decrement below zero into a borrow.
  assign sum      = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign diff     = {1'b0, count} - {{WIDTH{1'b0}}, 1'b1};
  assign hit_max  = (sum > {1'b0, MAX_COUNT});
  assign hit_zero = diff[WIDTH];
  assign boundary = step & ((up_dn == DIR_UP) ? hit_max : hit_zero);

  always_comb begin
    next_count = count;
    if (load) begin
      next_count = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX_COUNT)));
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (hit_max) next_count = (sat_mode == MODE_SAT) ? MAX_COUNT : '0;
        else         next_count = sum[WIDTH-1:0];
      end else begin
        if (hit_zero) next_count = (sat_mode == MODE_SAT) ? '0 : MAX_COUNT;
        else          next_count = diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RESET_VAL;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= next_count;
      tc    <= boundary;
      // A boundary on the same edge as clr_ovf keeps the flag set.
      if (boundary)     ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - self-checking randomized bench for updown_counter
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       sat_mode = 1'b0;
  logic       clr_ovf = 1'b0;

  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  int errors = 0;
  int checks = 0;

  int m_cnt[2];
  int m_tc[2];
  int m_ovf[2];
  int m_tick[2];
  int m_max[2] = '{15, 9};
  int m_rst[2] = '{0, 5};

  always #5 clk = ~clk;

  updown_counter #(
    .WIDTH     (4)
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    , .PRESCALE (P)
`endif
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .count(count_a), .tc(tc_a), .ovf(ovf_a)
  );

  updown_counter #(
    .WIDTH     (4),
    .MAX_COUNT (4'd9),
    .RESET_VAL (4'd5)
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    , .PRESCALE (P)
`endif
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .count(count_b), .tc(tc_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = m_rst[i]; m_tc[i] = 0; m_ovf[i] = 0; m_tick[i] = 0;
    end
  endfunction

  // Reference behaviour applied at each rising edge from the current inputs.
  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      int hit;
      int stepping;
      hit = 0;
      if (load) begin
        m_cnt[i]  = (int'(load_val) > m_max[i]) ? m_max[i] : int'(load_val);
        m_tick[i] = 0;
      end else if (enable) begin
        stepping  = (m_tick[i] == P - 1);
        m_tick[i] = (m_tick[i] + 1) % P;
        if (stepping) begin
          if (up_dn) begin
            if (m_cnt[i] == m_max[i]) begin
              hit = 1;
              m_cnt[i] = sat_mode ? m_max[i] : 0;
            end else m_cnt[i] = m_cnt[i] + 1;
          end else begin
            if (m_cnt[i] == 0) begin
              hit = 1;
              m_cnt[i] = sat_mode ? 0 : m_max[i];
            end else m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
      m_tc[i] = hit;
      if (hit) m_ovf[i] = 1;
      else if (clr_ovf) m_ovf[i] = 0;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, " a.count"}, int'(count_a), m_cnt[0]);
    check({tag, " a.tc"},    int'(tc_a),    m_tc[0]);
    check({tag, " a.ovf"},   int'(ovf_a),   m_ovf[0]);
    check({tag, " b.count"}, int'(count_b), m_cnt[1]);
    check({tag, " b.tc"},    int'(tc_b),    m_tc[1]);
    check({tag, " b.ovf"},   int'(ovf_b),   m_ovf[1]);
  endtask

  task automatic cycle(input string tag, input logic en, input logic ud,
                       input logic ld, input int lv, input logic sm,
                       input logic co);
    enable = en; up_dn = ud; load = ld; load_val = 4'(lv);
    sat_mode = sm; clr_ovf = co;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #20;
    check("reset a.count", int'(count_a), 0);
    check("reset b.count", int'(count_b), 5);
    check("reset a.tc", int'(tc_a), 0);
    check("reset a.ovf", int'(ovf_a), 0);
    @(negedge clk);
    reset = 1'b1;

    // Free-running up count with wrap.
    for (int i = 0; i < 16 * P; i++) cycle("wrap", 1, 1, 0, 0, 0, 0);
`ifndef UPDOWN_COUNTER_PRESCALE_EN
    check("wrap end a.count", int'(count_a), 0);
    check("wrap end a.tc", int'(tc_a), 1);
    check("wrap end a.ovf", int'(ovf_a), 1);
`endif

    // Down count saturating at zero.
    cycle("dsat load", 0, 0, 1, 2, 1, 0);
    for (int i = 0; i < 4 * P; i++) cycle("dsat", 1, 0, 0, 0, 1, 0);
`ifndef UPDOWN_COUNTER_PRESCALE_EN
    check("dsat end a.count", int'(count_a), 0);
    check("dsat end a.tc", int'(tc_a), 1);
`endif

    // Load beats enable and clamps to MAX_COUNT.
    cycle("clamp", 1, 1, 1, 12, 0, 0);
    check("clamp b.count", int'(count_b), 9);
    check("clamp b.tc", int'(tc_b), 0);
    for (int i = 0; i < P; i++) cycle("after clamp", 1, 1, 0, 0, 0, 0);
`ifndef UPDOWN_COUNTER_PRESCALE_EN
    check("after clamp b.count", int'(count_b), 0);
    check("after clamp b.tc", int'(tc_b), 1);
`endif

    // Sticky ovf: clear, then clear racing a boundary event.
    cycle("clr", 0, 1, 0, 0, 0, 1);
    check("clr a.ovf", int'(ovf_a), 0);
    cycle("to max", 0, 1, 1, 15, 0, 0);
    for (int i = 0; i < P; i++) cycle("set vs clr", 1, 1, 0, 0, 0, 1);
    check("set vs clr b.ovf", int'(ovf_b), 1);

    // Asynchronous reset between clock edges.
    cycle("load7", 0, 1, 1, 7, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check("async a.count", int'(count_a), 0);
    check("async b.count", int'(count_b), 5);
    check_all("async");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < P; i++) cycle("resume", 1, 1, 0, 0, 0, 0);
`ifndef UPDOWN_COUNTER_PRESCALE_EN
    check("resume a.count", int'(count_a), 1);
`endif

    // Load in the middle of a divide period restarts the spacing.
    for (int i = 0; i < 2; i++) cycle("mid", 1, 1, 0, 0, 0, 0);
    cycle("mid load", 1, 1, 1, 4, 0, 0);
    for (int i = 0; i < 2 * P + 1; i++) cycle("post load", 1, 1, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 15)),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
